// File: rtl/rst_release_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_release_seq
//  Description : Reset release sequencer for the liteeth ASIC port.
//                PRE presets every reset output asynchronously. Release is
//                synchronous and staged. It waits for a synchronized PLL lock.
//                Each downstream domain then leaves reset in index order,
//                HOLD_CYCLES CE-qualified edges apart.
//  Ports       : C        - clock, rising edge
//                PRE      - asynchronous active-high preset of all resets
//                CE       - clock enable for the hold counter / sequencing
//                LOCK     - asynchronous PLL lock (synchronized internally)
//                SOFT_RST - synchronous software reset request
//                RST_OUT  - per-domain active-high resets, bit 0 released first
//                DONE     - all domains released, sequencer in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_release_seq #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                C,
    input  logic                PRE,
    input  logic                CE,
    input  logic                LOCK,
    input  logic                SOFT_RST,
    output logic [N_STAGES-1:0] RST_OUT,
    output logic                DONE
);

    localparam int c_CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam int c_IDX_W = $clog2(N_STAGES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_STAGES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_lock_s;
    logic                   w_abort;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [N_STAGES-1:0]    r_rst;
    logic [N_STAGES-1:0]    w_rst_nxt;
    logic                   r_done;
    logic                   w_done_nxt;

    // ------------------------------------------------------------------------
    // LOCK synchronizer. It is cleared by PRE so that a fresh lock must
    // propagate through the full chain before any release can start.
    // ------------------------------------------------------------------------
    always_ff @(posedge C or posedge PRE) begin
        if (PRE) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], LOCK};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

    // Losing lock or a software request pulls everything back into reset.
    // This path is deliberately independent of CE.
    assign w_abort  = !w_lock_s || SOFT_RST;

    // ------------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------------
    always_ff @(posedge C or posedge PRE) begin
        if (PRE) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst   <= w_rst_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst;
        w_done_nxt  = r_done;

        unique case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt  = '0;
                w_idx_nxt  = '0;
                w_rst_nxt  = '1;
                w_done_nxt = 1'b0;
                if (w_lock_s && !SOFT_RST && CE) begin
                    w_state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                if (w_abort) begin
                    // Abort wins over a release that is due on the same edge.
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                end else if (CE) begin
                    if (r_cnt == c_CNT_LAST) begin
                        // RST_OUT is always a thermometer code (1..10..0).
                        // Clearing bit r_idx is therefore the same as shifting
                        // in a zero from the bottom.
                        w_rst_nxt = r_rst << 1;
                        w_idx_nxt = r_idx + c_IDX_ONE;
                        w_cnt_nxt = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end

            S_RUN: begin
                if (w_abort) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                end else begin
                    w_rst_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_rst_nxt   = '1;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign RST_OUT = r_rst;
    assign DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rst_release_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_release_seq
//  Description : Scoreboard bench for rst_release_seq. The stimulus process
//                schedules expected outputs (by clock-edge number) into a
//                queue. A monitor checks them on the falling edge.
//                Two builds are exercised: the default (3 stages, hold 16)
//                and a minimal one (1 stage, hold 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_release_seq;

    logic       C;
    logic       PRE;
    logic       CE;
    logic       LOCK;
    logic       SOFT_RST;
    logic [2:0] rst0;
    logic       done0;
    logic [0:0] rst1;
    logic       done1;

    rst_release_seq #(
        .N_STAGES    (3),
        .HOLD_CYCLES (16),
        .SYNC_STAGES (2)
    ) u_dut0 (
        .C        (C),
        .PRE      (PRE),
        .CE       (CE),
        .LOCK     (LOCK),
        .SOFT_RST (SOFT_RST),
        .RST_OUT  (rst0),
        .DONE     (done0)
    );

    rst_release_seq #(
        .N_STAGES    (1),
        .HOLD_CYCLES (1),
        .SYNC_STAGES (2)
    ) u_dut1 (
        .C        (C),
        .PRE      (PRE),
        .CE       (CE),
        .LOCK     (LOCK),
        .SOFT_RST (SOFT_RST),
        .RST_OUT  (rst1),
        .DONE     (done1)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [2:0] rst;
        logic       done;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    initial C = 1'b0;
    always #5 C = ~C;

    // Rising-edge count: edge number k sets cyc to k.
    always @(posedge C) cyc <= cyc + 1;

    task automatic push(input int c, input int d, input logic [2:0] r,
                        input logic dn, input string nm);
        exp_t e;
        e.cyc  = c;
        e.dut  = d;
        e.rst  = r;
        e.done = dn;
        e.name = nm;
        q.push_back(e);
    endtask

    // Returns 1 ns after rising edge number t.
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge C);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares every entry that is due on this cycle
    // ------------------------------------------------------------------------
    initial begin
        exp_t       e;
        logic [2:0] act_r;
        logic       act_d;
        forever begin
            @(negedge C);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    act_r = rst0;
                    act_d = done0;
                end else begin
                    act_r = {2'b00, rst1};
                    act_d = done1;
                end
                n_vec = n_vec + 1;
                if (e.cyc != cyc || act_r !== e.rst || act_d !== e.done) begin
                    n_err = n_err + 1;
                    $display("FAIL %s (dut%0d, edge %0d, checked at %0d): got rst=%b done=%b, expected rst=%b done=%b",
                             e.name, e.dut, e.cyc, cyc, act_r, act_d, e.rst, e.done);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        PRE      = 1'b1;
        LOCK     = 1'b1;
        CE       = 1'b1;
        SOFT_RST = 1'b0;

        // Power-up: PRE held for three edges, then released.
        for (int i = 1; i <= 3; i++) begin
            push(i, 0, 3'b111, 1'b0, "pre_hold");
            push(i, 1, 3'b001, 1'b0, "pre_hold_min");
        end
        push(5,  0, 3'b111, 1'b0, "sync_latency");
        push(6,  0, 3'b111, 1'b0, "hold_entry");
        push(6,  1, 3'b001, 1'b0, "min_hold_entry");
        push(7,  1, 3'b000, 1'b1, "min_first_release");
        push(21, 0, 3'b111, 1'b0, "pu_before_s0");
        push(22, 0, 3'b110, 1'b0, "pu_s0");
        push(37, 0, 3'b110, 1'b0, "pu_before_s1");
        push(38, 0, 3'b100, 1'b0, "pu_s1");
        push(53, 0, 3'b100, 1'b0, "pu_before_s2");
        push(54, 0, 3'b000, 1'b1, "pu_s2_done");
        wait_cyc(3);
        PRE = 1'b0;

        // Async PRE pulse in RUN, with no rising edge while it is high.
        wait_cyc(56);
        #1;
        PRE = 1'b1;
        push(56, 0, 3'b111, 1'b0, "async_pre");
        push(56, 1, 3'b001, 1'b0, "async_pre_min");
        push(57, 0, 3'b111, 1'b0, "post_pre_wait");
        push(59, 1, 3'b001, 1'b0, "min_reentry");
        push(60, 1, 3'b000, 1'b1, "min_rerelease");
        push(74, 0, 3'b111, 1'b0, "reseq_before_s0");
        push(75, 0, 3'b110, 1'b0, "reseq_s0");
        push(91, 0, 3'b100, 1'b0, "reseq_s1");
        push(106, 0, 3'b100, 1'b0, "reseq_before_s2");
        push(107, 0, 3'b000, 1'b1, "reseq_done");
        #4;
        PRE = 1'b0;

        // One-cycle SOFT_RST pulse in RUN.
        wait_cyc(110);
        SOFT_RST = 1'b1;
        push(110, 0, 3'b000, 1'b1, "run_before_soft");
        push(111, 0, 3'b111, 1'b0, "soft_abort");
        push(112, 0, 3'b111, 1'b0, "soft_reentry");
        push(127, 0, 3'b111, 1'b0, "soft_before_s0");
        push(128, 0, 3'b110, 1'b0, "soft_s0");
        wait_cyc(111);
        SOFT_RST = 1'b0;

        // Lock loss with the stage-1 hold counter at 10.
        wait_cyc(138);
        LOCK = 1'b0;
        push(140, 0, 3'b110, 1'b0, "lock_loss_sync");
        push(141, 0, 3'b111, 1'b0, "lock_loss_abort");
        wait_cyc(145);
        LOCK = 1'b1;
        push(147, 0, 3'b111, 1'b0, "relock_wait");
        push(163, 0, 3'b111, 1'b0, "relock_before_s0");
        push(164, 0, 3'b110, 1'b0, "relock_s0");
        push(195, 0, 3'b100, 1'b0, "relock_before_s2");
        push(196, 0, 3'b000, 1'b1, "relock_done");

        // CE toggling during HOLD: each stage takes 32 edges.
        wait_cyc(198);
        SOFT_RST = 1'b1;
        push(199, 0, 3'b111, 1'b0, "ce_abort");
        push(231, 0, 3'b111, 1'b0, "ce_before_s0");
        push(232, 0, 3'b110, 1'b0, "ce_s0");
        push(263, 0, 3'b110, 1'b0, "ce_before_s1");
        push(264, 0, 3'b100, 1'b0, "ce_s1");
        push(295, 0, 3'b100, 1'b0, "ce_before_s2");
        push(296, 0, 3'b000, 1'b1, "ce_done");
        wait_cyc(199);
        SOFT_RST = 1'b0;
        wait_cyc(200);
        while (cyc < 298) begin
            CE = ((cyc + 1) % 2) == 0;
            @(posedge C);
            #1;
        end

        // CE low in RUN while lock drops: the abort still happens.
        CE   = 1'b0;
        LOCK = 1'b0;
        push(300, 0, 3'b000, 1'b1, "ce0_run");
        push(301, 0, 3'b111, 1'b0, "ce0_lock_abort");
        push(310, 0, 3'b111, 1'b0, "ce0_wait_held");
        wait_cyc(302);
        LOCK = 1'b1;
        wait_cyc(310);
        CE = 1'b1;

        // SOFT_RST on the edge of a scheduled release, then held high.
        push(326, 0, 3'b111, 1'b0, "sched_before");
        push(327, 0, 3'b111, 1'b0, "soft_beats_release");
        push(335, 0, 3'b111, 1'b0, "soft_held");
        push(351, 0, 3'b111, 1'b0, "after_soft_before_s0");
        push(352, 0, 3'b110, 1'b0, "after_soft_s0");
        push(384, 0, 3'b000, 1'b1, "after_soft_done");
        wait_cyc(326);
        SOFT_RST = 1'b1;
        wait_cyc(335);
        SOFT_RST = 1'b0;

        wait_cyc(390);
        if (q.size() != 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL unchecked_entries: got %0d left in queue, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
